// File: rtl/memio_pkg.sv
// memio_pkg: state encoding, cpu_size encodings and IO channel stride shared by mem_io_bridge.
package memio_pkg;
  typedef enum logic [2:0] {IDLE, MEM_ACC, MEM_CAP, IO_WAIT, DONE} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  localparam int IO_STRIDE = 16;
endpackage

// File: rtl/memio_lane.sv
// memio_lane: store-data replication, byte strobes and zero-extended load-lane extraction.
module memio_lane import memio_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int OW = $clog2(DATA_W / 8)
) (
  input  logic [1:0]          i_size,
  input  logic [OW-1:0]       i_off,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W-1:0]   i_rdata,
  output logic [DATA_W/8-1:0] o_strb,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W-1:0]   o_rdata
);
  localparam int NB = DATA_W / 8;
  always_comb begin
    o_wdata = i_size == SZ_BYTE ? {NB{i_wdata[7:0]}} : i_size == SZ_HALF ? {(NB/2){i_wdata[15:0]}} : i_wdata;
    o_strb  = i_size == SZ_BYTE ? NB'(1) << i_off : i_size == SZ_HALF ? NB'(3) << i_off : '1;
    o_rdata = i_size == SZ_BYTE ? DATA_W'(i_rdata[i_off*8 +: 8]) :
              i_size == SZ_HALF ? DATA_W'(i_rdata[i_off*8 +: 16]) : i_rdata;
  end
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: CPU load/store bridge to a sync RAM and a bank of handshaked IO channels.
// Optional MEM_IO_TIMEOUT_EN: abort an IO access with cpu_err after TIMEOUT cycles without ready.
module mem_io_bridge import memio_pkg::*; #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 32,
  parameter int          IO_CH   = 4,
  parameter int          IO_DW   = 16,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
  parameter int          TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [1:0]             cpu_size,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_stall,
  output logic                   cpu_err,
  output logic                   mem_en,
  output logic [DATA_W/8-1:0]    mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [IO_CH-1:0]       io_sel,
  output logic                   io_we,
  output logic [IO_DW-1:0]       io_wdata,
  input  logic [IO_CH*IO_DW-1:0] io_rdata,
  input  logic [IO_CH-1:0]       io_ready
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr, w_off;
  logic [DATA_W-1:0]   r_wdata, r_rdata, w_ldata;
  logic [1:0]          r_size;
  logic                r_we, r_err, w_io, w_bad, w_acc, w_rdy, w_to;
  logic [2:0]          r_ch, w_ch;
  logic [NB-1:0]       w_strb;
  memio_lane #(.DATA_W(DATA_W), .OW(OW)) u_lane (
    .i_size(r_size), .i_off(r_addr[OW-1:0]), .i_wdata(r_wdata), .i_rdata(mem_rdata),
    .o_strb(w_strb), .o_wdata(mem_wdata), .o_rdata(w_ldata)
  );
  // IO addresses are range-checked against the channel count; memory addresses against alignment
  assign w_io  = cpu_addr >= ADDR_W'(IO_BASE);
  assign w_off = cpu_addr - ADDR_W'(IO_BASE);
  assign w_ch  = 3'(w_off >> $clog2(IO_STRIDE));
  assign w_bad = w_io ? w_off >= ADDR_W'(IO_CH * IO_STRIDE) :
                 cpu_size == SZ_ILL || (cpu_size == SZ_HALF && cpu_addr[0]) ||
                 (cpu_size == SZ_WORD && cpu_addr[1:0] != 2'b00);
  assign w_acc     = r_state == IDLE && cpu_req;
  assign io_sel    = r_state == IO_WAIT ? IO_CH'(1) << r_ch : '0;
  assign w_rdy     = |(io_ready & io_sel);
  assign io_we     = r_state == IO_WAIT && r_we;
  assign io_wdata  = r_wdata[IO_DW-1:0];
  assign mem_en    = r_state == MEM_ACC;
  assign mem_we    = mem_en && r_we ? w_strb : '0;
  assign mem_addr  = {r_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign cpu_stall = rst_n && cpu_req && r_state != DONE;
  assign cpu_rdata = r_rdata;
  assign cpu_err   = r_err;
`ifdef MEM_IO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= r_state == IO_WAIT ? r_cnt + 1'b1 : '0;
  assign w_to = r_cnt == CW'(TIMEOUT - 1);
`else
  assign w_to = TIMEOUT < 0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = cpu_req ? (w_bad ? DONE : w_io ? IO_WAIT : MEM_ACC) : IDLE;
      MEM_ACC: w_next = r_we ? DONE : MEM_CAP;
      MEM_CAP: w_next = DONE;
      IO_WAIT: w_next = w_rdy || w_to ? DONE : IO_WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_ch    <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_acc) begin
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
        r_size  <= cpu_size;
        r_we    <= cpu_we;
        r_ch    <= w_ch;
        r_err   <= w_bad;
        r_rdata <= '0;
      end
      if (r_state == MEM_CAP) r_rdata <= w_ldata;
      if (r_state == IO_WAIT && w_rdy && !r_we) r_rdata <= DATA_W'(io_rdata[r_ch*IO_DW +: IO_DW]);
      if (r_state == IO_WAIT && !w_rdy && w_to) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed accesses with a scoreboard queue checked by a separate monitor.
module tb_mem_io_bridge;
  logic        clk = 1'b0, rst_n = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0, cpu_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_stall, cpu_err, mem_en, io_we;
  logic [3:0]  mem_we, io_sel, io_ready;
  logic [15:0] io_wdata;
  logic [63:0] io_rdata = {16'h4444, 16'h3333, 16'h1234, 16'h1111};
  logic [31:0] ram [0:63] = '{default: 32'h0};
  int          io_cnt = 0, io_dly = 0;
  logic [3:0]  io_mask = 4'h0, io_noise = 4'h0;
  int          n_vec = 0, n_bad = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          st, nm, ni;
    logic [3:0]  strb;
    logic [31:0] wd, ma;
    logic [3:0]  sel;
    logic        iwe;
    logic [15:0] iwd;
  } exp_t;
  exp_t q[$];

  mem_io_bridge #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cpu_err(cpu_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .io_sel(io_sel), .io_we(io_we),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ready(io_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= ram[mem_addr[7:2]];
    end

  // selected-channel ready rises after io_dly selected cycles; io_noise drives other channels
  always @(posedge clk) io_cnt <= (|io_sel) ? io_cnt + 1 : 0;
  assign io_ready = (io_cnt >= io_dly ? io_mask : 4'h0) | io_noise;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic err, input int st, input int nm,
                              input int ni, input logic [3:0] strb, input logic [31:0] wd,
                              input logic [31:0] ma, input logic [3:0] sel, input logic iwe,
                              input logic [15:0] iwd);
    exp_t e;
    e.rd = rd; e.err = err; e.st = st; e.nm = nm; e.ni = ni; e.strb = strb;
    e.wd = wd; e.ma = ma; e.sel = sel; e.iwe = iwe; e.iwd = iwd;
    return e;
  endfunction

  initial begin : monitor
    int st, nm, ni;
    logic [3:0] strb, sel;
    logic [31:0] wd, ma;
    logic iwe;
    logic [15:0] iwd;
    exp_t e;
    st = 0; nm = 0; ni = 0; strb = 0; sel = 0; wd = 0; ma = 0; iwe = 0; iwd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st = 0; nm = 0; ni = 0; strb = 0;
      end else begin
        if (cpu_stall) st++;
        if (mem_en) begin
          nm++; ma = mem_addr; strb |= mem_we;
          if (|mem_we) wd = mem_wdata;
        end
        if (|io_sel) begin
          ni++; sel = io_sel; iwe = io_we; iwd = io_wdata;
        end
        if (cpu_req && !cpu_stall) begin
          if (q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = q.pop_front();
            chk("rdata", cpu_rdata, e.rd);
            chk("err", cpu_err, e.err);
            chk("stall_cycles", st, e.st);
            chk("mem_en_cycles", nm, e.nm);
            chk("io_sel_cycles", ni, e.ni);
            chk("strobes", strb, e.strb);
            if (e.nm > 0) chk("mem_addr", ma, e.ma);
            if (e.strb != 0) chk("mem_wdata", wd, e.wd);
            if (e.ni > 0) begin
              chk("io_sel", sel, e.sel);
              chk("io_we", iwe, e.iwe);
              if (e.iwe) chk("io_wdata", iwd, e.iwd);
            end
          end
          st = 0; nm = 0; ni = 0; strb = 0;
        end
      end
    end
  end

  task automatic access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input exp_t e);
    bit done = 0;
    @(posedge clk); #1;
    q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = !cpu_stall;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (!done) begin
      chk("done_timeout", 0, 1);
      q.delete();
      rst_n = 1'b0; #1; rst_n = 1'b1;
    end else begin
      @(negedge clk);
      chk("rdata_hold", cpu_rdata, e.rd);
      chk("err_hold", cpu_err, e.err);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int act;
    cpu_req = 1'b1; cpu_addr = 32'h10; cpu_size = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_io_sel", io_sel, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_err", cpu_err, 0);
    cpu_req = 1'b0;
    rst_n = 1'b1;
    access(1, 2'b10, 32'h10, 32'hDEADBEEF, mk(0, 0, 2, 1, 0, 4'hF, 32'hDEADBEEF, 32'h10, 0, 0, 0));
    access(0, 2'b10, 32'h10, 0, mk(32'hDEADBEEF, 0, 3, 1, 0, 0, 0, 32'h10, 0, 0, 0));
    access(1, 2'b00, 32'h13, 32'h123456AB, mk(0, 0, 2, 1, 0, 4'b1000, 32'hABABABAB, 32'h10, 0, 0, 0));
    access(0, 2'b00, 32'h13, 0, mk(32'hAB, 0, 3, 1, 0, 0, 0, 32'h10, 0, 0, 0));
    access(1, 2'b01, 32'h22, 32'h9999CAFE, mk(0, 0, 2, 1, 0, 4'b1100, 32'hCAFECAFE, 32'h20, 0, 0, 0));
    access(0, 2'b01, 32'h22, 0, mk(32'hCAFE, 0, 3, 1, 0, 0, 0, 32'h20, 0, 0, 0));
    access(0, 2'b10, 32'h20, 0, mk(32'hCAFE0000, 0, 3, 1, 0, 0, 0, 32'h20, 0, 0, 0));
    access(0, 2'b00, 32'h11, 0, mk(32'hBE, 0, 3, 1, 0, 0, 0, 32'h10, 0, 0, 0));
    io_dly = 4; io_mask = 4'b0010; io_noise = 4'b1101;
    access(0, 2'b10, 32'hFFFF_FC10, 0, mk(32'h1234, 0, 6, 0, 5, 0, 0, 0, 4'b0010, 0, 0));
    io_dly = 0; io_mask = 4'b1000; io_noise = 4'b0000;
    access(1, 2'b11, 32'hFFFF_FC30, 32'h5555BEEF, mk(0, 0, 2, 0, 1, 0, 0, 0, 4'b1000, 1, 16'hBEEF));
    io_mask = 4'b0001; io_noise = 4'b1110;
    access(0, 2'b00, 32'hFFFF_FC00, 0, mk(32'h1111, 0, 2, 0, 1, 0, 0, 0, 4'b0001, 0, 0));
    io_mask = 4'b0100; io_noise = 4'b0000;
    access(0, 2'b01, 32'hFFFF_FC2D, 0, mk(32'h3333, 0, 2, 0, 1, 0, 0, 0, 4'b0100, 0, 0));
    io_mask = 4'b0000;
    access(0, 2'b01, 32'h21, 0, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    access(0, 2'b10, 32'hFFFF_FC40, 0, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    access(1, 2'b11, 32'h0, 32'h1, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    access(1, 2'b10, 32'h12, 32'h1, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef MEM_IO_TIMEOUT_EN
    io_noise = 4'b1011;
    access(0, 2'b10, 32'hFFFF_FC20, 0, mk(0, 1, 9, 0, 8, 0, 0, 0, 4'b0100, 0, 0));
    io_noise = 4'b0000;
`endif
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'hFFFF_FC20;
    repeat (3) @(posedge clk);
    #2;
    chk("io_wait_sel", io_sel, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("abort_io_sel", io_sel, 0);
    chk("abort_stall", cpu_stall, 0);
    chk("abort_mem_we", mem_we, 0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    act = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_en || (|io_sel) || (|mem_we)) act++;
    end
    chk("post_reset_activity", act, 0);
    access(0, 2'b10, 32'h10, 0, mk(32'hABADBEEF, 0, 3, 1, 0, 0, 0, 32'h10, 0, 0, 0));
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
